// File: rtl/interfaz_pspl_mc.sv
// PS-PL command frontend serving N_CHAN PL backends over one PS command/data port.
// Commands and data are registered once; the FSM acts only on the registered copies.
module interfaz_pspl_mc #(
    parameter int DATA_WIDTH       = 32,
    parameter int BUFFER_IN_WIDTH  = 64,
    parameter int BUFFER_OUT_WIDTH = 64,
    parameter int N_CHAN           = 4,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [7:0]                         ctrl_in,
    output logic [7:0]                         ctrl_out,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic [N_CHAN-1:0]                  sync,
    input  logic [N_CHAN-1:0]                  ack,
    output logic [BUFFER_IN_WIDTH-1:0]         buffer_in,
    input  logic [N_CHAN*BUFFER_OUT_WIDTH-1:0] buffer_out,
    output logic                               error
);

    localparam int NW_IN  = (BUFFER_IN_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int NW_OUT = (BUFFER_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int NW_MAX = (NW_IN > NW_OUT) ? NW_IN : NW_OUT;
    localparam int KW     = $clog2(NW_MAX + 1);
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_RST        = 4'd1;
    localparam logic [3:0] S_RST_SYNC   = 4'd2;
    localparam logic [3:0] S_CALC       = 4'd3;
    localparam logic [3:0] S_CALC_SYNC  = 4'd4;
    localparam logic [3:0] S_SCAN       = 4'd5;
    localparam logic [3:0] S_SCAN_SYNC  = 4'd6;
    localparam logic [3:0] S_PRINT      = 4'd7;
    localparam logic [3:0] S_PRINT_SYNC = 4'd8;
    localparam logic [3:0] S_ERR        = 4'd9;

    localparam logic [3:0] CMD_IDLE       = 4'd0;
    localparam logic [3:0] CMD_RESET      = 4'd1;
    localparam logic [3:0] CMD_CALC       = 4'd2;
    localparam logic [3:0] CMD_SCAN       = 4'd3;
    localparam logic [3:0] CMD_PRINT      = 4'd4;
    localparam logic [3:0] CMD_SCAN_SYNC  = 4'd9;
    localparam logic [3:0] CMD_PRINT_SYNC = 4'd10;

    localparam logic [3:0] ST_TIMEOUT  = 4'd11;
    localparam logic [3:0] ST_BAD_CHAN = 4'd12;

    logic [7:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            state;
    logic [3:0]            chan;
    logic [KW-1:0]         k;
    logic [TW-1:0]         tcnt;
    logic [1:0]            phase;
    logic                  ack_lo;
    logic [3:0]            err_code;

    logic [3:0]                 cmd;
    logic                       bad_chan;
    logic [N_CHAN-1:0]          chan_mask;
    logic                       ack_sel;
    logic [KW-1:0]              k_inc;
    logic                       timed_out;
    logic [BUFFER_IN_WIDTH-1:0] scan_next;
    logic [DATA_WIDTH-1:0]      print_word;
    logic [3:0]                 status;

    assign cmd       = ctrl_q[3:0];
    assign bad_chan  = ({1'b0, ctrl_q[7:4]} >= 5'(N_CHAN));
    assign ack_sel   = |(ack & chan_mask);
    assign k_inc     = (k == {KW{1'b1}}) ? k : k + 1'b1;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign ctrl_out  = {chan, status};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        chan_mask = '0;
        for (int c = 0; c < N_CHAN; c++)
            chan_mask[c] = (chan == 4'(c));
    end

    // Word k of the SCAN buffer is overwritten bit by bit; bits past the buffer width simply do not exist.
    always_comb begin
        scan_next = buffer_in;
        for (int b = 0; b < BUFFER_IN_WIDTH; b++)
            if (k == KW'(b / DATA_WIDTH))
                scan_next[b] = data_q[b % DATA_WIDTH];
    end

    always_comb begin
        print_word = '0;
        for (int c = 0; c < N_CHAN; c++)
            for (int b = 0; b < BUFFER_OUT_WIDTH; b++)
                if (chan == 4'(c) && k == KW'(b / DATA_WIDTH))
                    print_word[b % DATA_WIDTH] = buffer_out[c*BUFFER_OUT_WIDTH + b];
    end

    always_comb begin
        case (state)
            S_IDLE:       status = 4'd6;
            S_RST:        status = CMD_RESET;
            S_RST_SYNC:   status = 4'd7;
            S_CALC:       status = CMD_CALC;
            S_CALC_SYNC:  status = 4'd8;
            S_SCAN:       status = CMD_SCAN;
            S_SCAN_SYNC:  status = 4'd9;
            S_PRINT:      status = CMD_PRINT;
            S_PRINT_SYNC: status = 4'd10;
            S_ERR:        status = err_code;
            default:      status = 4'd6;
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q    <= '0;
            data_q    <= '0;
            state     <= S_IDLE;
            chan      <= '0;
            k         <= '0;
            tcnt      <= '0;
            phase     <= '0;
            ack_lo    <= 1'b0;
            err_code  <= '0;
            data_out  <= '0;
            sync      <= '0;
            buffer_in <= '0;
            error     <= 1'b0;
        end else begin
            ctrl_q <= ctrl_in;
            data_q <= data_in;
            if (cmd == CMD_RESET && state != S_RST && state != S_RST_SYNC) begin
                state  <= S_RST;
                ack_lo <= 1'b0;
                sync   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        k     <= '0;
                        tcnt  <= '0;
                        phase <= '0;
                        if (cmd == CMD_CALC || cmd == CMD_SCAN || cmd == CMD_PRINT) begin
                            chan <= ctrl_q[7:4];
                            if (cmd != CMD_SCAN && bad_chan) begin
                                state    <= S_ERR;
                                err_code <= ST_BAD_CHAN;
                                error    <= 1'b1;
                            end else if (cmd == CMD_CALC)
                                state <= S_CALC;
                            else if (cmd == CMD_SCAN)
                                state <= S_SCAN;
                            else
                                state <= S_PRINT;
                        end
                    end
                    S_RST: begin
                        sync      <= '0;
                        buffer_in <= '0;
                        error     <= 1'b0;
                        k         <= '0;
                        tcnt      <= '0;
                        if (ack == '0) begin
                            ack_lo <= 1'b1;
                            if (ack_lo)
                                state <= S_RST_SYNC;
                        end else
                            ack_lo <= 1'b0;
                    end
                    S_RST_SYNC, S_CALC_SYNC:
                        if (cmd == CMD_IDLE) state <= S_IDLE;
                    S_CALC: begin
                        tcnt <= tcnt + 1'b1;
                        if (timed_out) begin
                            state    <= S_ERR;
                            sync     <= '0;
                            error    <= 1'b1;
                            err_code <= ST_TIMEOUT;
                        end else begin
                            // Request, wait for the ack to rise, drop the request, wait for the ack to fall.
                            case (phase)
                                2'd0: begin
                                    sync  <= chan_mask;
                                    phase <= 2'd1;
                                end
                                2'd1: if (ack_sel) begin
                                    sync  <= '0;
                                    phase <= 2'd2;
                                end
                                2'd2: if (!ack_sel) state <= S_CALC_SYNC;
                                default: phase <= 2'd0;
                            endcase
                        end
                    end
                    S_SCAN:
                        if (cmd == CMD_SCAN_SYNC) begin
                            buffer_in <= scan_next;
                            state     <= S_SCAN_SYNC;
                        end
                    S_SCAN_SYNC:
                        if (cmd == CMD_SCAN) begin
                            k     <= k_inc;
                            state <= S_SCAN;
                        end else if (cmd == CMD_IDLE)
                            state <= S_IDLE;
                    S_PRINT: begin
                        data_out <= print_word;
                        if (cmd == CMD_PRINT_SYNC) state <= S_PRINT_SYNC;
                    end
                    S_PRINT_SYNC:
                        if (cmd == CMD_PRINT) begin
                            k     <= k_inc;
                            state <= S_PRINT;
                        end else if (cmd == CMD_IDLE)
                            state <= S_IDLE;
                    S_ERR: begin
                        sync  <= '0;
                        error <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
